// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs
//   Oversampling UART receiver: configurable data width, stop bits and baud
//   divider. Each bit is resolved by a 3-sample majority vote around mid-bit.
//   The receiver has a 2-flop input synchroniser and a valid/ready output
//   handshake with overrun, framing-error and break detection.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> adds parameter PARITY_ODD and a parity bit after the data
//     undefined -> frame is start + DATA_BITS + STOP_BITS, parity_err_o = 0
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit (>= 8)
//   DATA_BITS     data bits per frame (5..9), LSB first
//   STOP_BITS     stop bits checked (1 or 2)
//   SPREAD        offset of the outer vote samples from mid-bit (< CLKS_PER_BIT/4)
//   PARITY_ODD    (parity build only) 0 = even, 1 = odd
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rx_sig_i       raw serial line, asynchronous, idle high
//   data_o         received word, stable while data_valid_o
//   data_valid_o   word available, held until accepted
//   data_ready_i   consumer accepts when data_valid_o && data_ready_i
//   parity_err_o   parity mismatch for the held word
//   frame_err_o    one-cycle pulse: a stop bit was voted low
//   break_det_o    one-cycle pulse: framing error with all data/parity low
//   overrun_o      one-cycle pulse: frame completed while the old word was
//                  still held and not being accepted
//   rx_busy_o      high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ovs #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int SPREAD       = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_sig_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_det_o,
  output logic                 overrun_o,
  output logic                 rx_busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] T_S0   = TW'(H - SPREAD);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_S2   = TW'(H + SPREAD);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_e;

  state_e                 state_q;
  logic                   sync1_q, sync2_q;
  logic [TW-1:0]          t_q;
  logic [IW-1:0]          idx_q;
  logic                   stop_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   samp0_q, samp1_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   data_valid_q;
  logic                   frame_err_q;
  logic                   break_det_q;
  logic                   overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   parity_err_q;
`endif

  logic rs;
  logic s0_eff, s1_eff;
  logic vote_d;
  logic vote_now;
  logic t_end;
  logic all_zero_d;

  assign rs = sync2_q;

  // With SPREAD == 0 all three samples fall in the vote cycle itself, so the
  // stored samples would be stale; use the live synchronised line instead.
  assign s0_eff   = (SPREAD == 0) ? rs : samp0_q;
  assign s1_eff   = (SPREAD == 0) ? rs : samp1_q;
  assign vote_d   = (s0_eff & s1_eff) | (s0_eff & rs) | (s1_eff & rs);
  assign vote_now = (t_q == T_S2);
  assign t_end    = (t_q == T_LAST);

`ifdef UART_RX_PARITY_EN
  assign all_zero_d = (shift_q == '0) && !par_q;
`else
  assign all_zero_d = (shift_q == '0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      t_q          <= '0;
      idx_q        <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      samp0_q      <= 1'b0;
      samp1_q      <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_sig_i;
      sync2_q     <= sync1_q;
      frame_err_q <= 1'b0;
      break_det_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Plain accept; a delivery later in this block overrides it.
      if (data_valid_q && data_ready_i) begin
        data_valid_q <= 1'b0;
      end

      // Bit timer and outer samples run in every bit-timed state.
      if (state_q != S_IDLE && state_q != S_FLUSH) begin
        t_q <= t_end ? '0 : t_q + 1'b1;
        if (t_q == T_S0) samp0_q <= rs;
        if (t_q == T_S1) samp1_q <= rs;
      end

      case (state_q)
        S_IDLE: begin
          // The cycle that sees the falling edge counts as T=0 of the start
          // bit, so the timer continues from 1.
          if (!rs) begin
            state_q <= S_START;
            t_q     <= TW'(1);
          end
        end

        S_START: begin
          if (vote_now && vote_d) begin
            state_q <= S_IDLE;
          end else if (t_end) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end

        S_DATA: begin
          if (vote_now) shift_q[idx_q] <= vote_d;
          if (t_end) begin
            if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q    <= S_PARITY;
`else
              state_q    <= S_STOP;
              stop_idx_q <= 1'b0;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (vote_now) par_q <= vote_d;
          if (t_end) begin
            state_q    <= S_STOP;
            stop_idx_q <= 1'b0;
          end
        end
`endif

        S_STOP: begin
          if (vote_now) begin
            if (!vote_d) begin
              frame_err_q <= 1'b1;
              break_det_q <= all_zero_d;
              state_q     <= S_FLUSH;
            end else if (stop_idx_q == LAST_STOP) begin
              // Deliver without waiting for the end of the stop bit.
              state_q <= S_IDLE;
              if (data_valid_q && !data_ready_i) begin
                overrun_q <= 1'b1;
              end else begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= (^shift_q) ^ par_q ^ PARITY_ODD;
`endif
              end
            end
          end else if (t_end) begin
            // Only reachable after a good first stop bit with STOP_BITS == 2.
            stop_idx_q <= 1'b1;
          end
        end

        S_FLUSH: begin
          if (rs) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign frame_err_o  = frame_err_q;
  assign break_det_o  = break_det_q;
  assign overrun_o    = overrun_q;
  assign rx_busy_o    = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ovs
//   Self-checking bench for uart_rx_ovs at CLKS_PER_BIT=16, SPREAD=2, 8N1
//   (8E1 when UART_RX_PARITY_EN is defined). Frames are built bit by bit from
//   a byte; the expected word is simply the byte that was put on the line.
// ---------------------------------------------------------------------------
module tb_uart_rx_ovs;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int SPR = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, perr, ferr, brk, ovr, busy;

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       busy;
    longint     c;
  } rec_t;

  rec_t got_q[$];
  int   n_ferr = 0, n_brk = 0, n_ovr = 0;

  uart_rx_ovs #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .SPREAD      (SPR)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_sig_i    (rx),
    .data_o      (data),
    .data_valid_o(valid),
    .data_ready_i(ready),
    .parity_err_o(perr),
    .frame_err_o (ferr),
    .break_det_o (brk),
    .overrun_o   (ovr),
    .rx_busy_o   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every accepted word and count error pulses.
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back('{d: data, pe: perr, busy: busy, c: cyc});
    if (ferr) n_ferr <= n_ferr + 1;
    if (brk)  n_brk  <= n_brk + 1;
    if (ovr)  n_ovr  <= n_ovr + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame. gbit/goff invert the line for one cycle at that bit
  // (0 = start) and cycle offset; gbit < 0 means no glitch.
  task automatic send_frame(input logic [7:0] d, input logic par, input int gbit,
                            input int goff, output longint stop_c);
    logic fq[$];
    fq.push_back(1'b0);
    for (int i = 0; i < 8; i++) fq.push_back(d[i]);
    if (PAR_EN) fq.push_back(par);
    fq.push_back(1'b1);
    stop_c = 0;
    for (int b = 0; b < fq.size(); b++) begin
      if (b == fq.size() - 1) stop_c = cyc;
      for (int off = 0; off < CPB; off++) begin
        rx = fq[b] ^ ((b == gbit) && (off == goff));
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    longint sc;
    int     f0, b0, o0;
    logic [7:0] exp_q[$];

    // Reset state
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(3);
    check_eq("reset_outputs", {data, valid, perr, ferr, brk, ovr, busy}, '0);
    rst_n = 1'b1;
    tick(5);
    check_eq("idle_busy", busy, 1'b0);

    // Single frame 0x35 with ready high
    ready = 1'b1; got_q.delete(); f0 = n_ferr; b0 = n_brk; o0 = n_ovr;
    send_frame(8'h35, ^8'h35, -1, 0, sc);
    tick(20);
    check_eq("f35_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check_eq("f35_data", got_q[0].d, 8'h35);
      check_eq("f35_busy_at_valid", got_q[0].busy, 1'b0);
      check_eq("f35_latency", 32'(got_q[0].c - sc), 2 + H + SPR + 1);
    end
    check_eq("f35_err_pulses", (n_ferr - f0) + (n_brk - b0) + (n_ovr - o0), 0);

    // 3-cycle glitch on idle line
    got_q.delete(); f0 = n_ferr; b0 = n_brk;
    rx = 1'b0; tick(3); rx = 1'b1;
    tick(2);
    check_eq("glitch_started", busy, 1'b1);
    tick(16);
    check_eq("glitch_rejected_busy", busy, 1'b0);
    check_eq("glitch_no_word", got_q.size(), 0);
    check_eq("glitch_no_flags", (n_ferr - f0) + (n_brk - b0), 0);

    // Back-to-back frames with ready low -> overrun
    ready = 1'b0; got_q.delete(); f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hA5, ^8'hA5, -1, 0, sc);
    send_frame(8'h3C, ^8'h3C, -1, 0, sc);
    tick(20);
    check_eq("ovr_valid_held", valid, 1'b1);
    check_eq("ovr_data_kept", data, 8'hA5);
    check_eq("ovr_pulse_count", n_ovr - o0, 1);
    check_eq("ovr_no_ferr", n_ferr - f0, 0);
    ready = 1'b1; tick(1); ready = 1'b0;
    check_eq("accept_drops_valid", valid, 1'b0);
    check_eq("accept_data_holds", data, 8'hA5);
    check_eq("accept_count", got_q.size(), 1);

    // Line held low for 12 bit times -> one framing error + break
    ready = 1'b1; got_q.delete(); f0 = n_ferr; b0 = n_brk;
    rx = 1'b0; tick(12 * CPB);
    check_eq("brk_ferr_count", n_ferr - f0, 1);
    check_eq("brk_break_count", n_brk - b0, 1);
    check_eq("brk_no_word", got_q.size(), 0);
    check_eq("brk_flush_busy", busy, 1'b1);
    rx = 1'b1; tick(4);
    check_eq("brk_release_idle", busy, 1'b0);
    send_frame(8'h7E, ^8'h7E, -1, 0, sc);
    tick(20);
    check_eq("after_brk_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("after_brk_data", got_q[0].d, 8'h7E);

    // One-cycle inversion at T=H of data bit 3
    got_q.delete();
    send_frame(8'h0F, ^8'h0F, 4, H, sc);
    tick(20);
    check_eq("vote_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("vote_data", got_q[0].d, 8'h0F);

    // Reset mid-frame: outputs clear at once, no word, no pulses
    got_q.delete(); f0 = n_ferr; b0 = n_brk; o0 = n_ovr;
    rx = 1'b0; tick(40);
    rst_n = 1'b0; #1;
    check_eq("midrst_outputs", {data, valid, busy}, '0);
    rx = 1'b1; tick(2); rst_n = 1'b1;
    tick(12 * CPB);
    check_eq("midrst_no_word", got_q.size(), 0);
    check_eq("midrst_no_pulses", (n_ferr - f0) + (n_brk - b0) + (n_ovr - o0), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 has even weight, so a parity bit of 1 is wrong.
    got_q.delete();
    send_frame(8'h03, 1'b1, -1, 0, sc);
    tick(20);
    send_frame(8'h03, 1'b0, -1, 0, sc);
    tick(20);
    check_eq("par_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("par_bad_data", got_q[0].d, 8'h03);
      check_eq("par_bad_flag", got_q[0].pe, 1'b1);
      check_eq("par_good_flag", got_q[1].pe, 1'b0);
    end
`endif

    // Randomised frames, gaps and single-cycle glitches inside data bits
    got_q.delete(); f0 = n_ferr; b0 = n_brk; o0 = n_ovr;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int g;
      d = 8'($urandom_range(0, 255));
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
      exp_q.push_back(d);
      send_frame(d, ^d, g, int'($urandom_range(0, CPB - 1)), sc);
      tick(int'($urandom_range(0, 30)));
    end
    tick(30);
    check_eq("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("rand_data[%0d]", i), got_q[i].d, exp_q[i]);
      check_eq($sformatf("rand_perr[%0d]", i), got_q[i].pe, 1'b0);
    end
    check_eq("rand_no_pulses", (n_ferr - f0) + (n_brk - b0) + (n_ovr - o0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
